// File: rtl/clk_freq_meter_pkg.sv
// Shared state encoding and default sizing for the PLL clock frequency meter.
// Latency and backpressure: none, types and constants only.
package clk_freq_meter_pkg;

   // Encodings are fixed so the state can be probed consistently across iceDAQ blocks.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_GATE   = 2'd2,
      ST_REPORT = 2'd3
   } meter_state_t;

   localparam int unsigned DEF_GATE_CYCLES = 600;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control and report bundle of the frequency meter: start/continuous in, counts out.
// Latency: count_valid follows REPORT by one cycle; no backpressure, reports are one-cycle pulses.
interface clk_freq_meter_if #(
   parameter int unsigned CNT_W = clk_freq_meter_pkg::DEF_CNT_W
);
   logic             start;
   logic             continuous;
   logic             busy;
   logic [CNT_W-1:0] count_out;
   logic             count_valid;
   logic             in_range;
   logic             overflow;

   modport master (
      output start,
      output continuous,
      input  busy,
      input  count_out,
      input  count_valid,
      input  in_range,
      input  overflow
   );

   modport slave (
      input  start,
      input  continuous,
      output busy,
      output count_out,
      output count_valid,
      output in_range,
      output overflow
   );
endinterface

// File: rtl/clk_freq_meter_sync_edge_detect.sv
// Synchronises an asynchronous level into clk and flags its rising edges.
// Latency: rise asserts STAGES cycles after the sampled edge, constant; no backpressure.
module clk_freq_meter_sync_edge_detect #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic d,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of sig_in over a fixed gate of clk cycles and reports count and range flags.
// Latency: report GATE_CYCLES+2 cycles after start is taken; start while busy is dropped, not queued.
module clk_freq_meter
   import clk_freq_meter_pkg::*;
#(
   parameter int unsigned      GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned      CNT_W       = DEF_CNT_W,
   parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
   parameter logic [CNT_W-1:0] MIN_COUNT   = '0,
   parameter logic [CNT_W-1:0] MAX_COUNT   = '1
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic            sig_in,
   clk_freq_meter_if.slave bus
);

   localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   // Range test as (count - MIN) <= (MAX - MIN), one bit wider so neither bound folds to a constant.
   localparam logic [CNT_W:0]   SPAN      = {1'b0, MAX_COUNT - MIN_COUNT};

   meter_state_t      state;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic              ovf_acc;
   logic              edge_rise;
   logic              edge_full;
   logic [CNT_W:0]    rel_cnt;

   clk_freq_meter_sync_edge_detect #(
      .STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .resetb (resetb),
      .d      (sig_in),
      .rise   (edge_rise)
   );

   assign edge_full = &edge_cnt;
   assign rel_cnt   = {1'b0, edge_cnt - MIN_COUNT};

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state           <= ST_IDLE;
         gate_cnt        <= '0;
         edge_cnt        <= '0;
         ovf_acc         <= 1'b0;
         bus.busy        <= 1'b0;
         bus.count_out   <= '0;
         bus.count_valid <= 1'b0;
         bus.in_range    <= 1'b0;
         bus.overflow    <= 1'b0;
      end else begin
         bus.count_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state    <= ST_ARM;
                  bus.busy <= 1'b1;
               end
            end
            // Edges seen while arming are discarded so every window spans exactly GATE_CYCLES samples.
            ST_ARM: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               ovf_acc  <= 1'b0;
               state    <= ST_GATE;
               bus.busy <= 1'b1;
            end
            ST_GATE: begin
               if (edge_rise) begin
                  if (edge_full) begin
                     ovf_acc <= 1'b1;
                  end else begin
                     edge_cnt <= edge_cnt + 1'b1;
                  end
               end
               if (gate_cnt == GATE_LAST) begin
                  state <= ST_REPORT;
               end else begin
                  gate_cnt <= gate_cnt + 1'b1;
               end
            end
            ST_REPORT: begin
               bus.count_out   <= edge_cnt;
               bus.overflow    <= ovf_acc;
               bus.in_range    <= !ovf_acc && (rel_cnt <= SPAN);
               bus.count_valid <= 1'b1;
               if (bus.continuous) begin
                  state <= ST_ARM;
               end else begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench: expected reports come from counting rising edges of the generated waveform.
// A monitor pops one expectation per count_valid pulse and compares cycle, count and flags.
module tb_clk_freq_meter;

   localparam int GATE = 600;
   localparam int CW   = 7;
   localparam int SYNC = 2;
   localparam int MINC = 50;
   localparam int MAXC = 120;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      int cnt;
      int ovf;
      int inr;
      int busy;
      int cyc;
   } exp_t;

   exp_t sb_q[$];

   logic clk    = 1'b0;
   logic resetb = 1'b0;
   logic sig_in = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   // Waveform: mode 0 periodic, 1 stuck high, 2 stuck low.
   int w_mode = 0;
   int w_per  = 6;
   int w_hi   = 3;
   int w_ph   = 0;

   clk_freq_meter_if #(.CNT_W(CW)) bus_if ();

   clk_freq_meter #(
      .GATE_CYCLES (GATE),
      .CNT_W       (CW),
      .SYNC_STAGES (SYNC),
      .MIN_COUNT   (7'd50),
      .MAX_COUNT   (7'd120)
   ) dut (
      .clk    (clk),
      .resetb (resetb),
      .sig_in (sig_in),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit sig_at(int k);
      if (w_mode == 1) return 1'b1;
      if (w_mode == 2) return 1'b0;
      return ((k + w_ph) % w_per) < w_hi;
   endfunction

   // sig_in value seen at posedge number k is sig_at(k).
   always @(negedge clk) sig_in = sig_at(cyc + 1);

   // Window whose first gated posedge follows posedge g: count edges in its GATE samples.
   function automatic exp_t model(int g, int last);
      exp_t e;
      int   raw = 0;
      for (int k = g + 1 - SYNC; k <= g + GATE - SYNC; k++) begin
         if (sig_at(k) && !sig_at(k - 1)) raw++;
      end
      e.cnt  = (raw > CMAX) ? CMAX : raw;
      e.ovf  = (raw > CMAX) ? 1 : 0;
      e.inr  = (e.ovf == 0 && raw >= MINC && raw <= MAXC) ? 1 : 0;
      e.busy = last ? 0 : 1;
      e.cyc  = g + GATE + 1;
      return e;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (resetb && bus_if.count_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_report", int'(bus_if.count_out), -1);
         end else begin
            e = sb_q.pop_front();
            check("report_cycle", cyc, e.cyc);
            check("count_out", int'(bus_if.count_out), e.cnt);
            check("overflow", int'(bus_if.overflow), e.ovf);
            check("in_range", int'(bus_if.in_range), e.inr);
            check("busy_at_report", int'(bus_if.busy), e.busy);
         end
      end
   end

   task automatic check_outputs_zero(string tag);
      check({tag, "_busy"}, int'(bus_if.busy), 0);
      check({tag, "_count_out"}, int'(bus_if.count_out), 0);
      check({tag, "_count_valid"}, int'(bus_if.count_valid), 0);
      check({tag, "_in_range"}, int'(bus_if.in_range), 0);
      check({tag, "_overflow"}, int'(bus_if.overflow), 0);
   endtask

   task automatic set_wave(int mode, int per, int hi, int ph);
      w_mode = mode;
      w_per  = per;
      w_hi   = hi;
      w_ph   = ph;
      repeat (6) @(negedge clk);
   endtask

   task automatic pulse_start(output int g);
      @(negedge clk);
      bus_if.start = 1'b1;
      g = cyc + 2;
      @(negedge clk);
      bus_if.start = 1'b0;
   endtask

   task automatic wait_drain(int limit);
      int n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("pending_reports", sb_q.size(), 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic one_window();
      int g;
      pulse_start(g);
      sb_q.push_back(model(g, 1));
      check("busy_after_start", int'(bus_if.busy), 1);
      wait_drain(GATE + 20);
   endtask

   task automatic wait_until(int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stimulus
      int g;
      int g2;
      int per;
      bus_if.start      = 1'b0;
      bus_if.continuous = 1'b0;

      // Reset held with a toggling input, then released: nothing reported yet.
      w_mode = 0; w_per = 5; w_hi = 2; w_ph = 0;
      repeat (10) @(negedge clk);
      check_outputs_zero("reset");
      resetb = 1'b1;
      repeat (20) @(negedge clk);
      check_outputs_zero("post_release");

      // Single window, period 6.
      set_wave(0, 6, 3, int'($urandom_range(0, 5)));
      one_window();

      // Continuous, period 8; continuous dropped inside the third window.
      set_wave(0, 8, 4, int'($urandom_range(0, 7)));
      bus_if.continuous = 1'b1;
      pulse_start(g);
      g2 = g + 2 * (GATE + 2);
      sb_q.push_back(model(g, 0));
      sb_q.push_back(model(g + GATE + 2, 0));
      sb_q.push_back(model(g2, 1));
      wait_until(g2 + GATE / 2);
      bus_if.continuous = 1'b0;
      wait_drain(GATE + 20);
      repeat (GATE + 50) @(negedge clk);
      check("busy_idle_after_cont", int'(bus_if.busy), 0);

      // Reset in the middle of a gate: report discarded, outputs cleared, then a normal run.
      set_wave(0, 6, 3, int'($urandom_range(0, 5)));
      pulse_start(g);
      wait_until(g + GATE / 2);
      resetb = 1'b0;
      sb_q.delete();
      @(negedge clk);
      check_outputs_zero("mid_gate_reset");
      resetb = 1'b1;
      repeat (GATE + 20) @(negedge clk);
      check_outputs_zero("after_mid_reset");
      one_window();

      // Period 4 saturates the 7-bit counter.
      set_wave(0, 4, 2, int'($urandom_range(0, 3)));
      one_window();

      // Stuck high: zero edges, below MIN; a second start during the gate is ignored.
      set_wave(1, 6, 3, 0);
      pulse_start(g);
      sb_q.push_back(model(g, 1));
      wait_until(g + GATE / 2);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      wait_drain(GATE + 20);
      repeat (GATE + 50) @(negedge clk);

      // Random waveforms across the overflow, in-range and below-range regions.
      for (int i = 0; i < 10; i++) begin
         per = int'($urandom_range(3, 16));
         if (i == 9) set_wave(2, per, 1, 0);
         else set_wave(0, per, int'($urandom_range(1, per - 1)), int'($urandom_range(0, per - 1)));
         one_window();
      end

      // Random continuous pair.
      per = int'($urandom_range(3, 16));
      set_wave(0, per, int'($urandom_range(1, per - 1)), int'($urandom_range(0, per - 1)));
      bus_if.continuous = 1'b1;
      pulse_start(g);
      sb_q.push_back(model(g, 0));
      sb_q.push_back(model(g + GATE + 2, 1));
      wait_until(g + GATE + 2 + GATE / 2);
      bus_if.continuous = 1'b0;
      wait_drain(GATE + 20);

      repeat (20) @(negedge clk);
      check("pending_at_end", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
